// File: rtl/simd_chunk_adder.sv
// Multi-lane add/subtract unit resolving CHUNK carry bits per cycle per lane.
// Define SIMD_CHUNK_ADDER_CARRY_EN to expose the registered per-lane carry port.
module simd_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int CHUNK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sub,
    input  logic [0:LANES*WIDTH-1]   a,
    input  logic [0:LANES*WIDTH-1]   b,
    output logic [0:LANES*WIDTH-1]   result,
    output logic                     done,
    output logic                     busy
`ifdef SIMD_CHUNK_ADDER_CARRY_EN
    ,
    output logic [0:LANES-1]         carry
`endif
);

    localparam int C  = WIDTH / CHUNK;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  opa        [LANES];
    logic [WIDTH-1:0]  opb        [LANES];
    logic [WIDTH-1:0]  shadow     [LANES];
    logic [WIDTH-1:0]  shadow_nxt [LANES];
    logic [CHUNK:0]    csum       [LANES];
    logic [LANES-1:0]  lcarry, lcarry_nxt;
    int unsigned       base;
    logic              accept, last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(C - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One chunk of every lane per cycle; the chunk sum is spliced into a copy of the shadow.
    always_comb begin
        base       = int'(cnt) * CHUNK;
        lcarry_nxt = lcarry;
        for (int unsigned i = 0; i < LANES; i++) begin
            csum[i]       = {1'b0, opa[i][base +: CHUNK]} + {1'b0, opb[i][base +: CHUNK]}
                            + (CHUNK+1)'(lcarry[i]);
            shadow_nxt[i] = shadow[i];
            shadow_nxt[i][base +: CHUNK] = csum[i][CHUNK-1:0];
            lcarry_nxt[i] = csum[i][CHUNK];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            lcarry <= '0;
            result <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                opa[i]    <= '0;
                opb[i]    <= '0;
                shadow[i] <= '0;
            end
`ifdef SIMD_CHUNK_ADDER_CARRY_EN
            carry  <= '0;
`endif
        end else if (accept) begin
            // Subtraction is a + ~b + 1, with the +1 injected as every lane's carry-in.
            for (int unsigned i = 0; i < LANES; i++) begin
                opa[i] <= a[i*WIDTH +: WIDTH];
                opb[i] <= sub ? ~b[i*WIDTH +: WIDTH] : b[i*WIDTH +: WIDTH];
            end
            lcarry <= {LANES{sub}};
            cnt    <= '0;
        end else if (state == RUN) begin
            shadow <= shadow_nxt;
            lcarry <= lcarry_nxt;
            cnt    <= cnt + 1'b1;
            if (last) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    result[i*WIDTH +: WIDTH] <= shadow_nxt[i];
`ifdef SIMD_CHUNK_ADDER_CARRY_EN
                    carry[i] <= lcarry_nxt[i];
`endif
                end
            end
        end
    end

endmodule
